// File: rtl/mem_arbiter_pkg.sv
// Shared handshake, arbiter-state and grant types for the two-master memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    RAM_IDLE = 2'd0,
    RAM_WAIT = 2'd1,
    RAM_DONE = 2'd2
  } ram_state_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  // On contention: round-robin hands the port to whoever was not served last,
  // otherwise data access always wins.
  function automatic arb_state_t contended_owner(input logic round_robin, input grant_t last);
    if (round_robin && (last == GNT_D)) return ARB_GNT_I;
    return ARB_GNT_D;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and data requests onto one ram-style memory port,
// holding the grant until the slave reports DONE and idling one cycle between accesses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_ren,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_load,
  output ram_state_t        i_state,
  input  logic              d_ren,
  input  logic [3:0]        d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_store,
  output logic [31:0]       d_load,
  output ram_state_t        d_state,
  output logic              m_ren,
  output logic [3:0]        m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_store,
  input  logic [31:0]       m_load,
  input  ram_state_t        m_state
);

  arb_state_t state, state_next;
  grant_t     last_grant;
  logic       i_req, d_req, m_done;

  assign i_req  = i_ren;
  assign d_req  = d_ren | (|d_wen);
  assign m_done = (m_state == RAM_DONE);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= ARB_IDLE;
      last_grant <= GNT_I;
    end else begin
      state <= state_next;
      if (m_done && (state == ARB_GNT_I)) last_grant <= GNT_I;
      if (m_done && (state == ARB_GNT_D)) last_grant <= GNT_D;
    end
  end

  // Outputs are held at reset values while nrst is low, even with requests pending.
  always_comb begin
    state_next = state;
    m_ren      = 1'b0;
    m_wen      = 4'b0000;
    m_addr     = '0;
    m_store    = 32'h0;
    i_load     = 32'h0;
    d_load     = 32'h0;
    i_state    = RAM_IDLE;
    d_state    = RAM_IDLE;
    if (nrst) begin
      case (state)
        ARB_IDLE: begin
          i_state = i_req ? RAM_WAIT : RAM_IDLE;
          d_state = d_req ? RAM_WAIT : RAM_IDLE;
          if (i_req && d_req) state_next = contended_owner(ROUND_ROBIN, last_grant);
          else if (i_req)     state_next = ARB_GNT_I;
          else if (d_req)     state_next = ARB_GNT_D;
        end
        ARB_GNT_I: begin
          m_ren   = i_ren;
          m_addr  = i_addr;
          i_state = m_done ? RAM_DONE : RAM_WAIT;
          i_load  = m_done ? m_load : 32'h0;
          d_state = d_req ? RAM_WAIT : RAM_IDLE;
          if (m_done) state_next = ARB_IDLE;
        end
        ARB_GNT_D: begin
          m_ren   = d_ren;
          m_wen   = d_wen;
          m_addr  = d_addr;
          m_store = d_store;
          d_state = m_done ? RAM_DONE : RAM_WAIT;
          d_load  = m_done ? m_load : 32'h0;
          i_state = i_req ? RAM_WAIT : RAM_IDLE;
          if (m_done) state_next = ARB_IDLE;
        end
        default: state_next = ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural memory slave with variable latency,
// a reference word array for expected loads, and a monitor that pops on every DONE.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_ren;
  logic [31:0] i_addr;
  logic [31:0] i_load;
  ram_state_t  i_state;
  logic        d_ren;
  logic [3:0]  d_wen;
  logic [31:0] d_addr;
  logic [31:0] d_store;
  logic [31:0] d_load;
  ram_state_t  d_state;
  logic        m_ren;
  logic [3:0]  m_wen;
  logic [31:0] m_addr;
  logic [31:0] m_store;
  logic [31:0] m_load;
  ram_state_t  m_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] iq[$];
  logic [31:0] dq[$];
  int          served[$];
  logic [31:0] refmem[256];

  mem_arbiter #(.ROUND_ROBIN(1'b1), .ADDR_W(32)) dut (
    .clk(clk), .nrst(nrst),
    .i_ren(i_ren), .i_addr(i_addr), .i_load(i_load), .i_state(i_state),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_store(d_store),
    .d_load(d_load), .d_state(d_state),
    .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr), .m_store(m_store),
    .m_load(m_load), .m_state(m_state)
  );

  always #5 clk = ~clk;

  // Memory slave: LAT extra WAIT cycles after it first sees a request, DONE for one cycle,
  // read data only in DONE, byte writes committed at the end of DONE.
  logic [31:0] mem[256];
  ram_state_t  s_state;
  logic [1:0]  s_cnt;
  int          lat = 0;

  always @(posedge clk) begin
    if (!nrst) begin
      s_state <= RAM_IDLE;
      s_cnt   <= 2'd0;
    end else begin
      case (s_state)
        RAM_IDLE: if (m_ren || (m_wen != 4'b0000)) begin
          if (lat == 0) s_state <= RAM_DONE;
          else begin
            s_state <= RAM_WAIT;
            s_cnt   <= 2'(lat - 1);
          end
        end
        RAM_WAIT: if (s_cnt == 2'd0) s_state <= RAM_DONE; else s_cnt <= s_cnt - 2'd1;
        default: begin
          s_state <= RAM_IDLE;
          for (int b = 0; b < 4; b++)
            if (m_wen[b]) mem[m_addr[9:2]][8*b +: 8] <= m_store[8*b +: 8];
        end
      endcase
    end
  end

  assign m_state = s_state;
  assign m_load  = (s_state == RAM_DONE && m_ren) ? mem[m_addr[9:2]] : 32'h0;

  function automatic logic [31:0] initWord(input int k);
    return 32'h5A00_0000 ^ (k * 32'h0001_0203);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=event expected=none", name);
  endtask

  // Monitor: pops the scoreboard on each DONE and checks port invariants every cycle.
  logic        prev_active = 1'b0;
  logic        prev_done   = 1'b0;
  logic [31:0] prev_addr   = 32'h0;

  always @(negedge clk) begin
    if (i_state == RAM_DONE) begin
      served.push_back(0);
      if (iq.size() == 0) reportFail("i_unexpected_done");
      else checkOutput("i_load", i_load, iq.pop_front());
    end else checkOutput("i_load_idle_zero", i_load, 32'h0);
    if (d_state == RAM_DONE) begin
      served.push_back(1);
      if (dq.size() == 0) reportFail("d_unexpected_done");
      else checkOutput("d_load", d_load, dq.pop_front());
    end else checkOutput("d_load_idle_zero", d_load, 32'h0);
    if ((m_ren || m_wen != 4'b0000) && prev_active && !prev_done)
      checkOutput("m_addr_stable", m_addr, prev_addr);
    if (prev_done)
      checkOutput("m_quiet_after_done", {31'b0, m_ren || (m_wen != 4'b0000)}, 32'h0);
    prev_active <= m_ren || (m_wen != 4'b0000);
    prev_done   <= (i_state == RAM_DONE) || (d_state == RAM_DONE);
    prev_addr   <= m_addr;
  end

  // Issue one access for a master, predict its load from the reference array, wait for DONE.
  task automatic applyStimulus(input bit is_d, input logic ren, input logic [3:0] wen,
                               input logic [31:0] addr, input logic [31:0] store);
    int  idx = int'(addr[9:2]);
    bit  got = 1'b0;
    if (is_d) begin
      dq.push_back(ren ? refmem[idx] : 32'h0);
      for (int b = 0; b < 4; b++)
        if (wen[b]) refmem[idx][8*b +: 8] = store[8*b +: 8];
      d_ren = ren; d_wen = wen; d_addr = addr; d_store = store;
    end else begin
      iq.push_back(refmem[idx]);
      i_ren = 1'b1; i_addr = addr;
    end
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if ((is_d ? d_state : i_state) == RAM_DONE) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) reportFail(is_d ? "d_timeout" : "i_timeout");
    @(posedge clk); #1;
    if (is_d) begin d_ren = 1'b0; d_wen = 4'b0000; end
    else i_ren = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp_order[4];
    int i_done, d_done;
    logic [31:0] merged;
    ram_state_t  lone_seq[3];

    for (int k = 0; k < 256; k++) begin
      mem[k]    = initWord(k);
      refmem[k] = initWord(k);
    end
    nrst = 1'b0; i_ren = 1'b1; i_addr = 32'h10; d_ren = 1'b1; d_wen = 4'b0000;
    d_addr = 32'h44; d_store = 32'h0;

    // Reset held with both requests high.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput("rst_m_ren", {31'b0, m_ren}, 32'h0);
      checkOutput("rst_m_wen", {28'b0, m_wen}, 32'h0);
      checkOutput("rst_m_addr", m_addr, 32'h0);
      checkOutput("rst_m_store", m_store, 32'h0);
      checkOutput("rst_i_state", {30'b0, i_state}, {30'b0, RAM_IDLE});
      checkOutput("rst_d_state", {30'b0, d_state}, {30'b0, RAM_IDLE});
    end
    @(posedge clk); #1;
    nrst = 1'b1; i_ren = 1'b0; d_ren = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Lone fetch at 0x0: WAIT, WAIT, DONE with no data-side activity.
    lone_seq = '{RAM_WAIT, RAM_WAIT, RAM_DONE};
    iq.push_back(refmem[0]);
    i_ren = 1'b1; i_addr = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("lone_i_state", {30'b0, i_state}, {30'b0, lone_seq[c]});
      checkOutput("lone_d_state", {30'b0, d_state}, {30'b0, RAM_IDLE});
    end
    @(posedge clk); #1;
    i_ren = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Both masters held: last served was fetch, so data goes first, then strict alternation.
    served.delete();
    fork
      begin
        applyStimulus(1'b0, 1'b1, 4'b0000, 32'h04, 32'h0);
        applyStimulus(1'b0, 1'b1, 4'b0000, 32'h08, 32'h0);
      end
      begin
        applyStimulus(1'b1, 1'b1, 4'b0000, 32'h80, 32'h0);
        applyStimulus(1'b1, 1'b1, 4'b0000, 32'h84, 32'h0);
      end
    join
    exp_order = '{1, 0, 1, 0};
    checkOutput("rr_count", served.size(), 4);
    for (int k = 0; k < 4 && k < served.size(); k++)
      checkOutput("rr_order", served[k], exp_order[k]);

    // Partial byte write then read back the merged word.
    merged = {initWord(16) >> 16, 16'hCCDD};
    applyStimulus(1'b1, 1'b0, 4'b0011, 32'h40, 32'hAABBCCDD);
    checkOutput("merge_ref", refmem[16], merged);
    applyStimulus(1'b1, 1'b1, 4'b0000, 32'h40, 32'h0);

    // LAT=2: data request arrives while fetch owns the port.
    lat = 2;
    repeat (2) @(posedge clk); #1;
    iq.push_back(refmem[3]);
    dq.push_back(refmem[20]);
    i_ren = 1'b1; i_addr = 32'h0C;
    @(posedge clk); #1;
    d_ren = 1'b1; d_addr = 32'h50;
    i_done = -1; d_done = -1;
    for (int c = 1; c < 40 && d_done < 0; c++) begin
      @(negedge clk);
      if (i_state == RAM_DONE) i_done = c;
      if (d_state == RAM_DONE) d_done = c;
      else checkOutput("lat2_d_wait", {30'b0, d_state}, {30'b0, RAM_WAIT});
      @(posedge clk); #1;
      if (i_done == c) i_ren = 1'b0;
    end
    d_ren = 1'b0;
    checkOutput("lat2_i_done", i_done, 4);
    checkOutput("lat2_d_gap", d_done - i_done, 5);

    // Reset pulse while data owns the port and the slave is still waiting.
    repeat (2) @(posedge clk); #1;
    d_ren = 1'b1; d_addr = 32'h60;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("abort_d_wait", {30'b0, d_state}, {30'b0, RAM_WAIT});
    @(posedge clk); #1;
    nrst = 1'b0; d_ren = 1'b0;
    @(negedge clk);
    checkOutput("abort_d_idle", {30'b0, d_state}, {30'b0, RAM_IDLE});
    checkOutput("abort_m_ren", {31'b0, m_ren}, 32'h0);
    @(posedge clk); #1;
    nrst = 1'b1;
    repeat (6) @(posedge clk); #1;
    applyStimulus(1'b1, 1'b1, 4'b0000, 32'h60, 32'h0);

    // Randomised traffic: fetch reads from a read-only region, data reads/writes elsewhere.
    for (int round = 0; round < 3; round++) begin
      lat = int'($urandom_range(0, 2));
      fork
        for (int n = 0; n < 12; n++) begin
          applyStimulus(1'b0, 1'b1, 4'b0000, 32'($urandom_range(0, 15)) << 2, 32'h0);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        for (int n = 0; n < 12; n++) begin
          if ($urandom_range(0, 1) == 1)
            applyStimulus(1'b1, 1'b1, 4'b0000, 32'($urandom_range(16, 255)) << 2, 32'h0);
          else
            applyStimulus(1'b1, 1'b0, 4'($urandom_range(1, 15)),
                          32'($urandom_range(16, 255)) << 2, $urandom);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
      join
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("iq_drained", iq.size(), 0);
    checkOutput("dq_drained", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
